pkt_ingress_buf: RTL
====================

Name: pkt_ingress_buf

Overview:
- Store-and-forward packet buffer directly upstream of camera_adaptor.
- Accepts 520-bit flit packets from the network-side packet source.
- Holds each packet until its tail and metadata arrive, discarding malformed or oversized packets.
- Replays only complete, well-formed packets onto camera_adaptor's pktin_*/pkt_in_md* interface, honouring its pkt_data_alf back-pressure.

Parameters:
- DATA_DEPTH, 64: flit FIFO entries; must be a power of two.
- MD_DEPTH, 8: metadata FIFO entries (one per committed packet); must be a power of two.
- MAX_PKT_FLITS, 32: longest packet accepted, in flits.
- ALF_MARGIN, 8: free-flit threshold for asserting pkt_in_alf.

Ports:
- clk  in  1  single clock.
- areset  in  1  asynchronous active-high reset.
- pkt_in_data  in  520  upstream flit; [519:518]=type (10 head, 00 body, 01 tail, 11 single), [511:0] payload.
- pkt_in_en  in  1  flit valid.
- pkt_in_md  in  256  packet metadata; sampled only on a tail or single flit.
- pkt_in_md_en  in  1  metadata valid qualifier; when low on a tail, metadata is stored as zero.
- pkt_in_alf  out  1  almost-full to upstream.
- pktin_data  out  520  flit to camera_adaptor.
- pktin_en  out  1  flit valid to camera_adaptor.
- pkt_in_md  out  256  metadata to camera_adaptor (output-side port; distinct from the input above by direction, named per camera_adaptor's port).
- pkt_in_md_en  out  1  metadata valid; asserted only alongside the tail/single flit.
- pkt_data_alf  in  1  camera_adaptor almost-full.
- drop_cnt  out  16  dropped-packet counter; saturating.
- err_cnt  out  16  orphan-flit counter; saturating.

Naming note: because of the pkt_in_md name clash, the input-side metadata pair is implemented as pkt_src_md / pkt_src_md_en. Everything stated above for pkt_in_md / pkt_in_md_en on the input side applies to them.

Behaviour:
- Reset (async, areset=1):
  - all pointers, FIFOs, FSMs and counters clear;
  - pktin_en=0, pkt_in_md_en=0, pktin_data=0, pkt_in_md=0;
  - pkt_in_alf=0, drop_cnt=0, err_cnt=0.
  - Any packet partially written or partially sent is lost. Output resumes only on a later complete packet.
- Write side keeps two pointers into the flit FIFO: wr_ptr (speculative) and wr_commit (visible to the read side).
- Write FSM states are W_IDLE, W_PKT and W_DROP.
  - W_IDLE, head: write flit, flit count=1 -> W_PKT.
  - W_IDLE, single: write flit, push metadata, set wr_commit=wr_ptr+1; stay in W_IDLE.
  - W_IDLE, body or tail: discard, err_cnt++.
  - W_PKT, body: write flit, count++.
  - W_PKT, tail: write flit, push metadata, wr_commit=wr_ptr+1 -> W_IDLE.
  - W_PKT, head: roll back wr_ptr to wr_commit, drop_cnt++, then start the new packet in the same cycle; stay in W_PKT.
  - W_DROP: discard flits until a tail -> W_IDLE. A single in W_DROP is accepted as in W_IDLE.
- Overflow drop: any of the following, while in W_PKT or on a single in W_IDLE, triggers a drop.
  - Conditions: flit FIFO full; metadata FIFO full on the tail/single; count would exceed MAX_PKT_FLITS.
  - Action: roll back wr_ptr to wr_commit, drop_cnt++.
  - Next state: W_DROP if the offending flit is not a tail/single, else W_IDLE.
- pkt_in_alf:
  - is registered;
  - asserts when (DATA_DEPTH − occupancy measured from rd_ptr to wr_ptr) < ALF_MARGIN, or when metadata count ≥ MD_DEPTH−1.
- Read FSM states are R_IDLE and R_SEND.
  - R_IDLE -> R_SEND when the metadata FIFO is non-empty and pkt_data_alf=0.
  - In R_SEND, each cycle with pkt_data_alf=0 emits one flit (pktin_en=1). With pkt_data_alf=1, it emits pktin_en=0 and holds its position.
  - On the tail/single flit: pkt_in_md_en=1, pkt_in_md=metadata FIFO head; pop metadata -> R_IDLE.
  - Gaps inside a packet are permitted only while pkt_data_alf is asserted.
- Outputs are registered.
  - Latency: tail accepted at cycle T -> head emitted at T+2, provided no back-pressure and the read side is idle.
  - Back-to-back packets are separated by one idle cycle (the R_IDLE visit).
- Simultaneous write and read in the same cycle are permitted.
- Pointers wrap modulo DATA_DEPTH. Full/empty are distinguished by an extra MSB.
- Counters saturate at 16'hFFFF.

Test Plan:
- Normal packet: head, 15 bodies (payload [511:504]=f1..15), tail with md_en=1, md=256'h1 -> 17 flits out in order, unbroken; pkt_in_md_en=1 with md=1 on flit 17 only; drop_cnt=0.
- Orphan flits: body then tail with no preceding head -> no output; err_cnt=2.
- Oversize packet: 40-flit packet with MAX_PKT_FLITS=32 -> no output, drop_cnt=1. A following 3-flit packet is delivered intact.
- Back-pressure: hold pkt_data_alf=1 for cycles 3–7 of a 17-flit send -> pktin_en=0 during the hold; all 17 flits are still delivered with no duplication or loss.
- Head during W_PKT: head, 2 bodies, head, tail -> only the 2-flit packet is emitted; drop_cnt=1.
- Reset mid-send: areset pulsed after 5 flits are out -> pktin_en=0 immediately. A subsequent single-flit packet (type 11) is emitted alone with pkt_in_md_en=1.

Source files
------------

// File: rtl/pkt_ingress_buf_if.sv
// rtl/pkt_ingress_buf_if.sv - flit/metadata handshake bundle around the ingress buffer
interface pkt_ingress_buf_if;
    logic [519:0] pkt_in_data;
    logic         pkt_in_en;
    logic [255:0] pkt_src_md;
    logic         pkt_src_md_en;
    logic         pkt_in_alf;
    logic [519:0] pktin_data;
    logic         pktin_en;
    logic [255:0] pkt_in_md;
    logic         pkt_in_md_en;
    logic         pkt_data_alf;

    modport slave (
        input  pkt_in_data, pkt_in_en, pkt_src_md, pkt_src_md_en, pkt_data_alf,
        output pkt_in_alf, pktin_data, pktin_en, pkt_in_md, pkt_in_md_en
    );

    modport master (
        output pkt_in_data, pkt_in_en, pkt_src_md, pkt_src_md_en, pkt_data_alf,
        input  pkt_in_alf, pktin_data, pktin_en, pkt_in_md, pkt_in_md_en
    );
endinterface

// File: rtl/pkt_ingress_buf.sv
// rtl/pkt_ingress_buf.sv - store-and-forward packet buffer feeding camera_adaptor
// Packets become visible to the read side only once their tail commits.
module pkt_ingress_buf #(
    parameter int DATA_DEPTH    = 64,
    parameter int MD_DEPTH      = 8,
    parameter int MAX_PKT_FLITS = 32,
    parameter int ALF_MARGIN    = 8
) (
    input  logic               clk,
    input  logic               areset,
    pkt_ingress_buf_if.slave   bus,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        err_cnt
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int MW = $clog2(MD_DEPTH);
    localparam int CW = $clog2(MAX_PKT_FLITS + 2);
    localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DATA_DEPTH);
    localparam logic [AW:0]   MARGIN_V = (AW+1)'(ALF_MARGIN);
    localparam logic [AW:0]   ONE_P    = (AW+1)'(1);
    localparam logic [MW:0]   MD_FULL_V = (MW+1)'(MD_DEPTH);
    localparam logic [MW:0]   MD_ALF_V  = (MW+1)'(MD_DEPTH - 1);
    localparam logic [MW:0]   ONE_M    = (MW+1)'(1);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_PKT_FLITS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    logic [519:0] r_mem    [DATA_DEPTH];
    logic [255:0] r_md_mem [MD_DEPTH];

    wstate_t       r_wstate, w_wstate_n;
    rstate_t       r_rstate, w_rstate_n;
    logic [AW:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [AW:0]   w_wr_ptr_n, w_commit_n, w_base, w_base_inc;
    logic [MW:0]   r_md_wr, r_md_rd, w_md_cnt;
    logic [CW-1:0] r_cnt, w_cnt_n, w_cnt_inc;
    logic [1:0]    w_type, w_drop_inc;
    logic          w_wr_en, w_md_push, w_err_inc;
    logic          w_base_full, w_md_full, w_md_empty, w_cnt_ovf;
    logic          w_emit, w_pop, w_rd_last;
    logic [519:0]  w_rd_flit;
    logic [16:0]   w_drop_sum;

    logic [519:0]  r_pktin_data;
    logic [255:0]  r_pkt_in_md;
    logic          r_pktin_en, r_pkt_in_md_en, r_alf;
    logic [15:0]   r_drop_cnt, r_err_cnt;

    assign w_type     = bus.pkt_in_data[519:518];
    assign w_md_cnt   = r_md_wr - r_md_rd;
    assign w_md_full  = (w_md_cnt == MD_FULL_V);
    assign w_md_empty = (w_md_cnt == '0);
    // A head/single arriving in W_PKT first discards the open packet, so it lands at wr_commit.
    assign w_base      = (r_wstate == W_PKT && w_type[1]) ? r_wr_commit : r_wr_ptr;
    assign w_base_inc  = w_base + ONE_P;
    assign w_base_full = ((w_base - r_rd_ptr) == DEPTH_V);
    assign w_cnt_inc   = r_cnt + ONE_C;
    assign w_cnt_ovf   = (w_cnt_inc > MAX_V);
    assign w_rd_flit   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd_last   = w_rd_flit[518];
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'b0, w_drop_inc};

    always_comb begin
        w_wstate_n = r_wstate;
        w_wr_ptr_n = r_wr_ptr;
        w_commit_n = r_wr_commit;
        w_cnt_n    = r_cnt;
        w_wr_en    = 1'b0;
        w_md_push  = 1'b0;
        w_drop_inc = 2'd0;
        w_err_inc  = 1'b0;
        if (bus.pkt_in_en) begin
            if (w_type == T_SINGLE || (w_type == T_HEAD && r_wstate != W_DROP)) begin
                if (r_wstate == W_PKT) w_drop_inc = 2'd1;
                w_wr_ptr_n = r_wr_commit;
                if (w_base_full || (w_type == T_SINGLE && w_md_full)) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_wstate_n = (w_type == T_SINGLE) ? W_IDLE : W_DROP;
                end else begin
                    w_wr_en    = 1'b1;
                    w_wr_ptr_n = w_base_inc;
                    w_cnt_n    = ONE_C;
                    if (w_type == T_SINGLE) begin
                        w_md_push  = 1'b1;
                        w_commit_n = w_base_inc;
                        w_wstate_n = W_IDLE;
                    end else begin
                        w_wstate_n = W_PKT;
                    end
                end
            end else if (r_wstate == W_PKT) begin
                if (w_base_full || w_cnt_ovf || (w_type[0] && w_md_full)) begin
                    w_drop_inc = 2'd1;
                    w_wr_ptr_n = r_wr_commit;
                    w_wstate_n = w_type[0] ? W_IDLE : W_DROP;
                end else begin
                    w_wr_en    = 1'b1;
                    w_wr_ptr_n = w_base_inc;
                    w_cnt_n    = w_cnt_inc;
                    if (w_type[0]) begin
                        w_md_push  = 1'b1;
                        w_commit_n = w_base_inc;
                        w_wstate_n = W_IDLE;
                    end
                end
            end else if (r_wstate == W_IDLE) begin
                w_err_inc = 1'b1;
            end else if (w_type == T_TAIL) begin
                w_wstate_n = W_IDLE;
            end
        end
    end

    always_comb begin
        w_rstate_n = r_rstate;
        w_emit     = 1'b0;
        case (r_rstate)
            R_IDLE: if (!w_md_empty && !bus.pkt_data_alf) w_rstate_n = R_SEND;
            R_SEND: if (!bus.pkt_data_alf) begin
                w_emit = 1'b1;
                if (w_rd_last) w_rstate_n = R_IDLE;
            end
            default: w_rstate_n = R_IDLE;
        endcase
    end
    assign w_pop = w_emit && w_rd_last;

    always_ff @(posedge clk) begin
        if (w_wr_en)   r_mem[w_base[AW-1:0]] <= bus.pkt_in_data;
        if (w_md_push) r_md_mem[r_md_wr[MW-1:0]] <= bus.pkt_src_md_en ? bus.pkt_src_md : '0;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wstate       <= W_IDLE;
            r_rstate       <= R_IDLE;
            r_wr_ptr       <= '0;
            r_wr_commit    <= '0;
            r_rd_ptr       <= '0;
            r_md_wr        <= '0;
            r_md_rd        <= '0;
            r_cnt          <= '0;
            r_pktin_data   <= '0;
            r_pktin_en     <= 1'b0;
            r_pkt_in_md    <= '0;
            r_pkt_in_md_en <= 1'b0;
            r_alf          <= 1'b0;
            r_drop_cnt     <= '0;
            r_err_cnt      <= '0;
        end else begin
            r_wstate       <= w_wstate_n;
            r_rstate       <= w_rstate_n;
            r_wr_ptr       <= w_wr_ptr_n;
            r_wr_commit    <= w_commit_n;
            r_cnt          <= w_cnt_n;
            r_pktin_en     <= w_emit;
            r_pkt_in_md_en <= w_pop;
            if (w_md_push) r_md_wr <= r_md_wr + ONE_M;
            if (w_emit) begin
                r_pktin_data <= w_rd_flit;
                r_rd_ptr     <= r_rd_ptr + ONE_P;
            end
            if (w_pop) begin
                r_pkt_in_md <= r_md_mem[r_md_rd[MW-1:0]];
                r_md_rd     <= r_md_rd + ONE_M;
            end
            r_alf <= ((DEPTH_V - (r_wr_ptr - r_rd_ptr)) < MARGIN_V) || (w_md_cnt >= MD_ALF_V);
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.pktin_data   = r_pktin_data;
    assign bus.pktin_en     = r_pktin_en;
    assign bus.pkt_in_md    = r_pkt_in_md;
    assign bus.pkt_in_md_en = r_pkt_in_md_en;
    assign bus.pkt_in_alf   = r_alf;
    assign drop_cnt         = r_drop_cnt;
    assign err_cnt          = r_err_cnt;
endmodule
